mod_exp: RTL and testbench
==========================

MOD_EXP -- requirements
Module: mod_exp

Interface
REQ-001 Parameter: EXP_BITS, default 256, number of exponent bits scanned (1..256).
REQ-002 Parameter: WIDTH, default 256, operand and modulus width; fixed to the mul_mod width.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  single-cycle request; sampled only in IDLE.
REQ-006 Port: base  input  WIDTH  base b; b < n is the caller's responsibility.
REQ-007 Port: exp  input  EXP_BITS  exponent e.
REQ-008 Port: n  input  WIDTH  modulus; n > 1 is the caller's responsibility.
REQ-009 Port: result  output  WIDTH  b^e mod n; holds its value until the next done.
REQ-010 Port: done  output  1  one-cycle pulse when result is updated.
REQ-011 Port: busy  output  1  high from the cycle after an accepted start through the done cycle.

Function
REQ-012 The operation SHALL be left-to-right square-and-multiply: r=1; for i=MSB..0 {r=r*r mod n; if e[i], r=r*b mod n}.
REQ-013 start in IDLE SHALL latch base, exp and n into internal registers; later changes on those inputs SHALL have no effect until the next start.
REQ-014 start while busy SHALL be ignored: no restart and no relatch.
REQ-015 FSM states: IDLE, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, NEXT, FIN.
REQ-016 Transitions:
- IDLE->SQR_REQ on start.
- SQR_REQ->SQR_WAIT after 1 cycle.
- SQR_WAIT->MUL_REQ on mul valid if e[i]=1, else ->NEXT.
- MUL_REQ->MUL_WAIT after 1 cycle.
- MUL_WAIT->NEXT on mul valid.
- NEXT->SQR_REQ with i-1 if i>0, else ->FIN.
- FIN->IDLE after 1 cycle.
REQ-017 SQR_REQ and MUL_REQ SHALL each assert mul ready for exactly one cycle, with operands (r,r) or (r,b) and modulus n.
REQ-018 r SHALL capture mul M only in the cycle mul valid is high; completion is detected from valid, never from a cycle count.
REQ-019 FIN SHALL load result from r and pulse done for one cycle.
REQ-020 Total multiplications SHALL equal EXP_BITS squarings plus popcount(e) multiplications.
REQ-021 e=0 SHALL give result=1.

Reset
REQ-022 reset SHALL force IDLE, i=EXP_BITS-1, r=1, result=0, done=0, busy=0, and SHALL reset the mul_mod instance on the same cycle.
REQ-023 reset mid-operation SHALL abandon the computation with no done pulse; the first start after reset SHALL run normally.

Configuration
REQ-024 Macro MOD_EXP_SKIP_LZ_EN: when defined, leading zero bits of e SHALL be skipped: i starts at the highest set bit, and e=0 goes IDLE->FIN with result=1 in 2 cycles; when undefined, all EXP_BITS bits SHALL be processed.
REQ-025 The result value SHALL be identical with and without the macro; only latency SHALL differ.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef and the WIDTH=256 constant.
REQ-027 There SHALL be exactly one sub-module instance, mul_mod, used in a time-shared way for squarings and multiplications.

Verification
REQ-028 base=4, exp=13, n=497, start -> a single done pulse, result=445; with the macro undefined, exactly 259 mul ready pulses.
REQ-029 base=5, exp=3, n=13 -> result=8; base=2, exp=10, n=1000 -> result=24.
REQ-030 base=3, exp=0, n=7 -> result=1; with the macro defined, done is 2 cycles after start.
REQ-031 A second start pulse while busy, with different operands -> ignored; the first result is unchanged and there is only one done pulse.
REQ-032 reset asserted during SQR_WAIT -> no done; busy=0 next cycle; a following start with 4,13,497 -> 445.

Source files
------------

// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the modular exponentiation engine.
package mod_exp_pkg;

  localparam int MOD_EXP_WIDTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SQR_REQ  = 3'd1,
    ST_SQR_WAIT = 3'd2,
    ST_MUL_REQ  = 3'd3,
    ST_MUL_WAIT = 3'd4,
    ST_NEXT     = 3'd5,
    ST_FIN      = 3'd6
  } state_t;

endpackage

// File: rtl/mod_exp_if.sv
// Request/result bundle of mod_exp: operands and start in, result/done/busy out.
interface mod_exp_if
  import mod_exp_pkg::*;
#(
  parameter int WIDTH    = MOD_EXP_WIDTH,
  parameter int EXP_BITS = 256
);

  logic                start;
  logic [WIDTH-1:0]    base;
  logic [EXP_BITS-1:0] exp;
  logic [WIDTH-1:0]    n;
  logic [WIDTH-1:0]    result;
  logic                done;
  logic                busy;

  modport master (
    output start, base, exp, n,
    input  result, done, busy
  );

  modport slave (
    input  start, base, exp, n,
    output result, done, busy
  );

endinterface

// File: rtl/mod_exp_mul_mod.sv
// Sequential modular multiplier m = a*b mod n (right-to-left shift-and-add);
// finishes as soon as the remaining multiplier bits are all zero.
module mod_exp_mul_mod
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = MOD_EXP_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             valid,
  output logic [WIDTH-1:0] m
);

  logic [WIDTH-1:0] a_r, b_r, acc_r, n_r, m_r;
  logic             run_r, valid_r;
  logic [WIDTH:0]   sum_s, dbl_s;
  logic [WIDTH-1:0] sum_dif_s, dbl_dif_s;
  logic [WIDTH-1:0] acc_s, b_dbl_s;

  // One reduction step: both partial values stay below 2n, so one subtract suffices
  always_comb begin
    sum_s     = {1'b0, acc_r} + {1'b0, b_r};
    dbl_s     = {b_r, 1'b0};
    sum_dif_s = sum_s[WIDTH-1:0] - n_r;
    dbl_dif_s = dbl_s[WIDTH-1:0] - n_r;
    acc_s     = acc_r;
    b_dbl_s   = dbl_s[WIDTH-1:0];
    if (a_r[0]) begin
      if (sum_s >= {1'b0, n_r}) begin
        acc_s = sum_dif_s;
      end else begin
        acc_s = sum_s[WIDTH-1:0];
      end
    end else begin
      acc_s = acc_r;
    end
    if (dbl_s >= {1'b0, n_r}) begin
      b_dbl_s = dbl_dif_s;
    end else begin
      b_dbl_s = dbl_s[WIDTH-1:0];
    end
  end

  // Operand capture, iteration and one-cycle valid pulse with the product
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      n_r     <= '0;
      m_r     <= '0;
      run_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (ready) begin
        a_r   <= a;
        b_r   <= b;
        n_r   <= n;
        acc_r <= '0;
        run_r <= 1'b1;
      end else if (run_r) begin
        if (a_r == '0) begin
          valid_r <= 1'b1;
          m_r     <= acc_r;
          run_r   <= 1'b0;
        end else begin
          acc_r <= acc_s;
          b_r   <= b_dbl_s;
          a_r   <= a_r >> 1;
        end
      end
    end
  end

  assign valid = valid_r;
  assign m     = m_r;

endmodule

// File: rtl/mod_exp.sv
// Left-to-right square-and-multiply b^e mod n over one time-shared multiplier.
// Optional MOD_EXP_SKIP_LZ_EN: skip leading zero exponent bits (latency only).
module mod_exp
  import mod_exp_pkg::*;
#(
  parameter int EXP_BITS = 256,
  parameter int WIDTH    = MOD_EXP_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  mod_exp_if.slave bus
);

  localparam int               IDX_W   = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_BITS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    idx_r, start_idx_s;
  logic [WIDTH-1:0]    base_r, n_r, r_r, result_r;
  logic [EXP_BITS-1:0] exp_r;
  logic                done_r, busy_r;
  logic                skip_all_s;
  logic                mul_ready_s, mul_valid_s;
  logic [WIDTH-1:0]    mul_b_s, mul_m_s;

`ifdef MOD_EXP_SKIP_LZ_EN
  function automatic logic [IDX_W-1:0] top_bit(input logic [EXP_BITS-1:0] e);
    logic [IDX_W-1:0] pos;
    pos = '0;
    for (int k = 0; k < EXP_BITS; k++) begin
      if (e[k]) begin
        pos = IDX_W'(k);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction
`endif

  // Starting bit index and the all-zero shortcut for a freshly accepted exponent
  always_comb begin
`ifdef MOD_EXP_SKIP_LZ_EN
    start_idx_s = top_bit(bus.exp);
    skip_all_s  = (bus.exp == '0);
`else
    start_idx_s = IDX_TOP;
    skip_all_s  = 1'b0;
`endif
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = skip_all_s ? ST_FIN : ST_SQR_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SQR_REQ:  state_s = ST_SQR_WAIT;
      ST_SQR_WAIT: begin
        if (mul_valid_s) begin
          state_s = exp_r[idx_r] ? ST_MUL_REQ : ST_NEXT;
        end else begin
          state_s = ST_SQR_WAIT;
        end
      end
      ST_MUL_REQ:  state_s = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mul_valid_s) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_MUL_WAIT;
        end
      end
      ST_NEXT: begin
        if (idx_r != '0) begin
          state_s = ST_SQR_REQ;
        end else begin
          state_s = ST_FIN;
        end
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Multiplier request: square uses (r,r), multiply uses (r,b)
  always_comb begin
    mul_ready_s = (state_r == ST_SQR_REQ) || (state_r == ST_MUL_REQ);
    if (state_r == ST_MUL_REQ) begin
      mul_b_s = base_r;
    end else begin
      mul_b_s = r_r;
    end
  end

  // State register, operand latch, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      idx_r    <= IDX_TOP;
      r_r      <= ONE;
      result_r <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      base_r   <= '0;
      exp_r    <= '0;
      n_r      <= '0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_r == ST_FIN);
      // a start accepted in the done cycle keeps busy asserted
      if ((state_r == ST_IDLE) && bus.start) begin
        busy_r <= 1'b1;
      end else if (done_r) begin
        busy_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            base_r <= bus.base;
            exp_r  <= bus.exp;
            n_r    <= bus.n;
            r_r    <= ONE;
            idx_r  <= start_idx_s;
          end
        end
        ST_SQR_WAIT, ST_MUL_WAIT: begin
          if (mul_valid_s) begin
            r_r <= mul_m_s;
          end
        end
        ST_NEXT: begin
          if (idx_r != '0) begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        ST_FIN:  result_r <= r_r;
        default: ;
      endcase
    end
  end

  mod_exp_mul_mod #(
    .WIDTH (WIDTH)
  ) mul_mod (
    .clk   (clk),
    .reset (reset),
    .ready (mul_ready_s),
    .a     (r_r),
    .b     (mul_b_s),
    .n     (n_r),
    .valid (mul_valid_s),
    .m     (mul_m_s)
  );

  assign bus.result = result_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_mod_exp.sv
// Scoreboard bench for mod_exp: expected results queued at start, checked on done.
module tb_mod_exp;
  import mod_exp_pkg::*;

  localparam int W     = 256;
  localparam int EB    = 256;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mod_exp_if #(.WIDTH(W), .EXP_BITS(EB)) bus ();

  mod_exp #(.EXP_BITS(EB), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;
  int done_cnt  = 0;
  int mul_cnt   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] b, input logic [EB-1:0] e,
                                        input logic [63:0] n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = EB - 1; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * b) % n;
    end
    return r;
  endfunction

  function automatic int exp_muls(input logic [EB-1:0] e);
    int pc;
    int top;
    pc  = 0;
    top = -1;
    for (int i = 0; i < EB; i++) begin
      if (e[i]) begin
        pc++;
        top = i;
      end
    end
`ifdef MOD_EXP_SKIP_LZ_EN
    return top + 1 + pc;
`else
    return EB + pc;
`endif
  endfunction

  // Done monitor and multiplier-request counter
  always @(negedge clk) begin
    if (dut.mul_ready_s === 1'b1) mul_cnt++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) check("spurious_done", W'(bus.done), W'(0));
      else check("result", bus.result, exp_q.pop_front());
    end
  end

  task automatic kick(input logic [W-1:0] b, input logic [EB-1:0] e, input logic [W-1:0] n);
    bus.base  = b;
    bus.exp   = e;
    bus.n     = n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= LIMIT) begin
      check({tag, "_timeout"}, W'(lat), W'(0));
      exp_q.delete();
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] b, input logic [EB-1:0] e,
                        input logic [W-1:0] n, input logic [W-1:0] want);
    int m0;
    int lat;
    exp_q.push_back(want);
    m0 = mul_cnt;
    kick(b, e, n);
    check({tag, "_busy"}, W'(bus.busy), W'(1));
    wait_done(tag, lat);
`ifdef MOD_EXP_SKIP_LZ_EN
    if (e == '0) check({tag, "_latency"}, W'(lat), W'(2));
`endif
    check({tag, "_muls"}, W'(mul_cnt - m0), W'(exp_muls(e)));
    bus.base = '1;
    bus.n    = '1;
    @(negedge clk);
    check({tag, "_done_pulse"}, W'(bus.done), W'(0));
    check({tag, "_busy_end"}, W'(bus.busy), W'(0));
    check({tag, "_hold"}, bus.result, want);
  endtask

  initial begin
    int d0;
    int m0;
    int lat;
    int k;
    logic [EB-1:0] e;
    logic [W-1:0]  rn;
    logic [W-1:0]  rb;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;
    bus.n     = '0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_state", W'(dut.state_r), W'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    run_op("v445", W'(4), EB'(13), W'(497), W'(445));
    run_op("v8", W'(5), EB'(3), W'(13), W'(8));
    run_op("v24", W'(2), EB'(10), W'(1000), W'(24));
    run_op("v1", W'(3), EB'(0), W'(7), W'(1));

    // second start while busy must be ignored
    exp_q.push_back(W'(445));
    d0 = done_cnt;
    m0 = mul_cnt;
    kick(W'(4), EB'(13), W'(497));
    repeat (10) @(negedge clk);
    kick(W'(5), EB'(3), W'(13));
    wait_done("ign", lat);
    check("ign_muls", W'(mul_cnt - m0), W'(exp_muls(EB'(13))));
    repeat (40) @(negedge clk);
    check("ign_done_count", W'(done_cnt - d0), W'(1));

    // reset in SQR_WAIT abandons the operation
    d0 = done_cnt;
    kick(W'(4), EB'(13), W'(497));
    k = 0;
    while (dut.state_r != ST_SQR_WAIT && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reach", W'(dut.state_r), W'(ST_SQR_WAIT));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", W'(bus.busy), W'(0));
    check("rst_mid_done", W'(bus.done), W'(0));
    repeat (300) @(negedge clk);
    check("rst_mid_no_done", W'(done_cnt - d0), W'(0));
    run_op("after_rst", W'(4), EB'(13), W'(497), W'(445));

    for (int t = 0; t < 2; t++) begin
      rn = W'($urandom_range(60, 3));
      rb = W'($urandom_range(32'(rn[31:0]) - 1, 0));
      for (int q = 0; q < EB / 32; q++) e[q*32 +: 32] = $urandom();
      run_op($sformatf("rand%0d", t), rb, e, rn, W'(model(rb[63:0], e, rn[63:0])));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
